// File: rtl/soundgen_poly_pwm_if.sv
// soundgen_poly_pwm_if: voice write port of the polyphonic sound core
interface soundgen_poly_pwm_if #(
   parameter int NCH   = 4,
   parameter int ACC_W = 16
);
   localparam int AW = NCH > 1 ? $clog2(NCH) : 1;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [ACC_W-1:0] wr_tune;
   logic [1:0]       wr_mode;
   modport master (output wr_en, wr_addr, wr_tune, wr_mode);
   modport slave  (input  wr_en, wr_addr, wr_tune, wr_mode);
endinterface

// File: rtl/soundgen_poly_pwm.sv
// soundgen_poly_pwm: NCH phase-accumulator voices mixed into an N-bit PWM DAC
module soundgen_poly_pwm #(
   parameter int N     = 8,
   parameter int NCH   = 4,
   parameter int ACC_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   soundgen_poly_pwm_if.slave   wr,
   output logic                 pwm_out,
   output logic                 sample_tick,
   output logic [N-1:0]         level
);
   localparam int AW = NCH > 1 ? $clog2(NCH) : 1;
   localparam int SH = $clog2(NCH);
   localparam int SW = N + AW;
   localparam logic [N-1:0] TOP = {N{1'b1}};

   logic [N-1:0]     cnt, duty, mix;
   logic [ACC_W-1:0] phase [NCH];
   logic [ACC_W-1:0] tune [NCH];
   logic [1:0]       mode [NCH];
   logic [N-1:0]     samp [NCH];
   logic [SW-1:0]    sum;
   logic             wrap;

   assign wrap  = cnt == TOP;
   assign level = duty;

   // Free-running PWM counter; duty reloads only at the wrap so a period is never split
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt         <= '0;
         duty        <= '0;
         mix         <= '0;
         pwm_out     <= 1'b0;
         sample_tick <= 1'b0;
      end else begin
         cnt         <= cnt + 1'b1;
         duty        <= wrap ? mix : duty;
         mix         <= sum[SH +: N];
         pwm_out     <= cnt < duty;
         sample_tick <= cnt == TOP - 1'b1;
      end

   // Voice state: writes take tune/mode; phases step with the pre-write tune at each wrap, off-mode write clears phase
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            phase[i] <= '0;
            tune[i]  <= '0;
            mode[i]  <= 2'b00;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (wr.wr_en && wr.wr_addr == AW'(i)) begin
               tune[i] <= wr.wr_tune;
               mode[i] <= wr.wr_mode;
            end
            if (wr.wr_en && wr.wr_addr == AW'(i) && wr.wr_mode == 2'b00)
               phase[i] <= '0;
            else if (wrap)
               phase[i] <= phase[i] + tune[i];
         end
      end

   for (genvar g = 0; g < NCH; g++) begin : g_voice
      logic [N-1:0] p;
      assign p = phase[g][ACC_W-1 -: N];
      assign samp[g] = mode[g] == 2'b01 ? {N{p[N-1]}} :
                       mode[g] == 2'b10 ? p :
                       mode[g] == 2'b11 ? (p[N-1] ? ~{p[N-2:0], 1'b0} : {p[N-2:0], 1'b0}) :
                       '0;
   end

   // Mixer sum, widened by AW bits so NCH full-scale voices cannot overflow
   always_comb begin
      sum = '0;
      for (int i = 0; i < NCH; i++)
         sum = sum + SW'(samp[i]);
   end
endmodule

// File: tb/tb_soundgen_poly_pwm.sv
// tb_soundgen_poly_pwm: directed checks of voices, mixer, PWM timing and async reset
module tb_soundgen_poly_pwm;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pwm_out, sample_tick;
   logic [7:0] level;
   logic [7:0] mc;
   int         total = 0;
   int         bad = 0;

   soundgen_poly_pwm_if #(.NCH(4), .ACC_W(16)) wr ();

   soundgen_poly_pwm #(.N(8), .NCH(4), .ACC_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr          (wr),
      .pwm_out     (pwm_out),
      .sample_tick (sample_tick),
      .level       (level)
   );

   always #5 clk = ~clk;

   // Reference period position: mirrors the expected counter value
   always @(posedge clk or posedge reset)
      if (reset) mc <= 8'd0;
      else mc <= mc + 8'd1;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      wr.wr_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [15:0] t, input logic [1:0] md);
      wr.wr_en = 1'b1;
      wr.wr_addr = a;
      wr.wr_tune = t;
      wr.wr_mode = md;
      @(negedge clk);
      wr.wr_en = 1'b0;
   endtask

   task automatic run_period(input string nm, input logic [7:0] exp, input bit do_wr = 1'b0,
                             input int wr_i = 0, input logic [1:0] a = 2'd0,
                             input logic [15:0] t = 16'd0, input logic [1:0] md = 2'd0);
      int g, hi, tk_bad, lv_bad;
      g = 0; hi = 0; tk_bad = 0; lv_bad = 0;
      while (mc != 8'd0 && g < 300) begin
         @(negedge clk);
         wr.wr_en = 1'b0;
         g++;
      end
      total++;
      if (g >= 300) begin bad++; $display("FAIL %s align: period start not reached, mc=%0d", nm, mc); end
      total++;
      if (level !== exp) begin bad++; $display("FAIL %s level_start: got %0d want %0d", nm, level, exp); end
      for (int i = 0; i < 256; i++) begin
         if (do_wr && i == wr_i) begin
            wr.wr_en = 1'b1; wr.wr_addr = a; wr.wr_tune = t; wr.wr_mode = md;
         end
         @(negedge clk);
         wr.wr_en = 1'b0;
         if (pwm_out === 1'b1) hi++;
         if (sample_tick !== (mc == 8'd255)) tk_bad++;
         if (i < 255 && level !== exp) lv_bad++;
      end
      total++;
      if (hi !== int'(exp)) begin bad++; $display("FAIL %s pwm_high: got %0d cycles want %0d", nm, hi, exp); end
      total++;
      if (tk_bad !== 0) begin bad++; $display("FAIL %s sample_tick: %0d wrong cycles want 0", nm, tk_bad); end
      total++;
      if (lv_bad !== 0) begin bad++; $display("FAIL %s level_hold: %0d wrong cycles want 0", nm, lv_bad); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      total++;
      if (pwm_out !== 1'b0) begin bad++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
      total++;
      if (sample_tick !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", sample_tick); end
      total++;
      if (level !== 8'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
      do_reset();
      run_period("idle0", 8'd0);
      run_period("idle1", 8'd0);
      run_period("idle2", 8'd0);
   endtask

   task automatic test_square();
      do_reset();
      do_write(2'd0, 16'h8000, 2'b01);
      run_period("sq1", 8'd0);
      run_period("sq2", 8'd63);
      run_period("sq3", 8'd0);
      run_period("sq4", 8'd63);
   endtask

   task automatic test_saw();
      do_reset();
      do_write(2'd1, 16'h0100, 2'b10);
      run_period("saw1", 8'd0);
      run_period("saw2", 8'd0);
      run_period("saw3", 8'd0);
      run_period("saw4", 8'd0);
      run_period("saw5", 8'd1);
      run_period("saw6", 8'd1);
      do_reset();
      do_write(2'd1, 16'h4000, 2'b10);
      run_period("sawq1", 8'd0);
      run_period("sawq2", 8'd16);
      run_period("sawq3", 8'd32);
      run_period("sawq4", 8'd48);
      run_period("sawq5", 8'd0);
   endtask

   task automatic test_triangle();
      do_reset();
      do_write(2'd2, 16'h4000, 2'b11);
      run_period("tri1", 8'd0);
      run_period("tri2", 8'd32);
      run_period("tri3", 8'd63);
      run_period("tri4", 8'd31);
      run_period("tri5", 8'd0);
   endtask

   task automatic test_all_voices();
      do_reset();
      for (int v = 0; v < 4; v++) do_write(2'(v), 16'h8000, 2'b01);
      run_period("all1", 8'd0);
      run_period("all2", 8'd255);
      run_period("all3", 8'd0);
      run_period("all4", 8'd255);
   endtask

   task automatic test_off_on_wrap();
      do_reset();
      do_write(2'd0, 16'h8000, 2'b01);
      run_period("off1", 8'd0, 1'b1, 255, 2'd0, 16'h0000, 2'b00);
      run_period("off2", 8'd63);
      run_period("off3", 8'd0);
      run_period("off4", 8'd0);
      do_reset();
      do_write(2'd0, 16'h4000, 2'b01);
      run_period("clr1", 8'd0, 1'b1, 255, 2'd0, 16'h0000, 2'b00);
      run_period("clr2", 8'd0, 1'b1, 100, 2'd0, 16'h4000, 2'b01);
      run_period("clr3", 8'd0);
      run_period("clr4", 8'd0);
      run_period("clr5", 8'd63);
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_write(2'd0, 16'h4000, 2'b10);
      run_period("rt1", 8'd0, 1'b1, 255, 2'd0, 16'h1000, 2'b10);
      run_period("rt2", 8'd16);
      run_period("rt3", 8'd32);
      run_period("rt4", 8'd36);
      run_period("rt5", 8'd40);
   endtask

   task automatic test_async_reset();
      int zb;
      zb = 0;
      do_reset();
      do_write(2'd0, 16'h8000, 2'b01);
      run_period("ar1", 8'd0);
      repeat (10) @(negedge clk);
      total++;
      if (pwm_out !== 1'b1) begin bad++; $display("FAIL ar_pwm_pre: got %b want 1", pwm_out); end
      #2 reset = 1'b1;
      #1;
      total++;
      if (pwm_out !== 1'b0) begin bad++; $display("FAIL ar_pwm_drop: got %b want 0", pwm_out); end
      total++;
      if (level !== 8'd0) begin bad++; $display("FAIL ar_level_drop: got %0d want 0", level); end
      repeat (3) begin
         @(negedge clk);
         if (pwm_out !== 1'b0 || sample_tick !== 1'b0 || level !== 8'd0) zb++;
      end
      total++;
      if (zb !== 0) begin bad++; $display("FAIL ar_hold: %0d nonzero cycles want 0", zb); end
      reset = 1'b0;
      run_period("ar_p0", 8'd0);
      run_period("ar_p1", 8'd0);
   endtask

   initial begin
      wr.wr_en = 1'b0;
      wr.wr_addr = 2'd0;
      wr.wr_tune = 16'd0;
      wr.wr_mode = 2'b00;
      test_reset();
      test_square();
      test_saw();
      test_triangle();
      test_all_voices();
      test_off_on_wrap();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
